ritc_lane_emulator_tx: RTL

- Transmit-side counterpart of the GLITC RITC datapath receiver.
- Serializes 48-bit parallel sample words onto 12 data lanes plus a reference-clock lane, as a RITC digitizer does.
- Used for loopback and bench test of the receive datapath's deserialization, bitslip and IDELAY alignment without real RITC silicon.
- Emits a fixed training pattern while training is requested; realigns its word phase on SYNC.

---
 rtl/ritc_tx_pkg.sv | 38 +++
 rtl/ritc_tx_fifo2.sv | 49 ++++
 rtl/ritc_lane_emulator_tx.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/ritc_tx_pkg.sv
// Shared constants, types and helpers for the RITC lane emulator transmitter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ritc_tx_pkg;

  localparam int NLANES = 12;
  localparam int NPHASE = 4;
  localparam int WORD_W = NLANES * NPHASE;

  // Per-lane training nibble, LSB goes out first (phase 0).
  localparam logic [NPHASE-1:0] DEF_TRAIN_PATTERN = 4'b1010;

  // PRBS-7, x^7 + x^6 + 1.
  localparam logic [6:0] PRBS_SEED = 7'h7F;
  localparam logic [6:0] PRBS_TAPS = 7'b110_0000;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic {
    WAIT_SYNC = 1'b0,
    RUN       = 1'b1
  } tx_state_e;

  // Word whose phase-p slice carries pat[p] on every lane.
  function automatic word_t train_word(input logic [NPHASE-1:0] pat);
    word_t w;
    w = '0;
    for (int p = 0; p < NPHASE; p++) begin
      w[p*NLANES +: NLANES] = {NLANES{pat[p]}};
    end
    return w;
  endfunction

  function automatic logic [6:0] prbs7_next(input logic [6:0] s);
    return {s[5:0], ^(s & PRBS_TAPS)};
  endfunction

endpackage

// File: rtl/ritc_tx_fifo2.sv
// Two-entry word FIFO with occupancy count.
// Latency: a pushed word is visible at the head on the following cycle (no bypass).
// Backpressure: pushes are ignored when full; caller derives ready from count.
//   push_vld/push_dat : write side
//   pop_rdy           : consume head this cycle (ignored when empty)
//   pop_vld/pop_dat   : head word
//   count             : entries held (0..2)
module ritc_tx_fifo2 #(
  parameter int W = 48
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_vld,
  input  logic [W-1:0] push_dat,
  input  logic         pop_rdy,
  output logic         pop_vld,
  output logic [W-1:0] pop_dat,
  output logic [1:0]   count
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic         push;
  logic         pop;

  assign pop_vld = (count != 2'd0);
  assign pop_dat = mem_q[rd_ptr_q];
  assign push    = push_vld && (count != 2'd2);
  assign pop     = pop_rdy && pop_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count    <= 2'd0;
    end else begin
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_dat;
  end

endmodule

// File: rtl/ritc_lane_emulator_tx.sv
// Serializes 48-bit sample words onto 12 RITC data lanes plus a refclk lane.
// Latency: a word accepted into an empty FIFO at cycle t is driven at the first phase-0 cycle >= t+2.
// Backpressure: ready_o drops while the 2-entry input FIFO is full.
//   clk_i, rst_n_i         : bit clock, async active-low reset (synchronously released)
//   dat_i/valid_i/ready_o  : word input, dat_i[p*12+l] -> lane l, phase p
//   sync_i                 : realign word phase to 0 (also leaves WAIT_SYNC)
//   train_i                : send training slots instead of data
//   lane_o, refclk_o       : serial outputs (refclk high in phases 0,1)
//   running_o              : high in RUN
//   uflow_cnt_o/uflow_clr_i: saturating count of empty data slots, sync clear
// Build option RITC_TX_PRBS_TRAIN_EN: training slots send PRBS-7 with lane l delayed l bits.
module ritc_lane_emulator_tx
  import ritc_tx_pkg::*;
#(
  parameter logic [NPHASE-1:0] TRAIN_PATTERN = DEF_TRAIN_PATTERN,
  parameter int                UFLOW_W       = 16
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic [WORD_W-1:0]  dat_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic               sync_i,
  input  logic               train_i,
  output logic [NLANES-1:0]  lane_o,
  output logic               refclk_o,
  output logic               running_o,
  output logic [UFLOW_W-1:0] uflow_cnt_o,
  input  logic               uflow_clr_i
);

  localparam logic [UFLOW_W-1:0] UFLOW_ONE = 1;

  // Reset asserts immediately but releases on a clock edge.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  tx_state_e         state_q;
  logic [1:0]        phase_q;
  word_t             slot_q;

  logic              fifo_vld;
  word_t             fifo_dat;
  logic [1:0]        fifo_cnt;

  logic              adv;
  logic [1:0]        phase_nxt;
  logic              sel;
  logic              pop_en;
  logic              uflow_hit;
  word_t             slot_nxt;
  word_t             cur_word;
  logic [NLANES-1:0] lane_nxt;

  assign ready_o = (fifo_cnt < 2'd2);

  ritc_tx_fifo2 #(.W(WORD_W)) u_fifo (
    .clk      (clk_i),
    .rst_n    (rst_n),
    .push_vld (valid_i),
    .push_dat (dat_i),
    .pop_rdy  (pop_en),
    .pop_vld  (fifo_vld),
    .pop_dat  (fifo_dat),
    .count    (fifo_cnt)
  );

`ifdef RITC_TX_PRBS_TRAIN_EN
  logic [6:0]        prbs_q;
  logic [NLANES-2:0] prbs_hist_q;
  logic              train_q;
  logic [NLANES-1:0] prbs_lanes;

  // Lane 0 is the live generator bit; lane l is that bit l cycles ago.
  assign prbs_lanes = {prbs_hist_q, prbs_q[6]};

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      prbs_q      <= PRBS_SEED;
      prbs_hist_q <= '0;
      train_q     <= 1'b0;
    end else begin
      prbs_q      <= sync_i ? PRBS_SEED : prbs7_next(prbs_q);
      prbs_hist_q <= {prbs_hist_q[NLANES-3:0], prbs_q[6]};
      if (sel) train_q <= train_i;
    end
  end
`endif

  always_comb begin
    adv       = sync_i || (state_q == RUN);
    phase_nxt = sync_i ? 2'd0 : phase_q + 2'd1;
    // A new slot is chosen on every edge that lands on phase 0,
    // including the one that applies a sync.
    sel       = adv && (phase_nxt == 2'd0);
    pop_en    = sel && !train_i && fifo_vld;
    uflow_hit = sel && !train_i && !fifo_vld;

    if (train_i)       slot_nxt = train_word(TRAIN_PATTERN);
    else if (fifo_vld) slot_nxt = fifo_dat;
    else               slot_nxt = '0;

    cur_word = sel ? slot_nxt : slot_q;

    case (phase_nxt)
      2'd0:    lane_nxt = cur_word[0*NLANES +: NLANES];
      2'd1:    lane_nxt = cur_word[1*NLANES +: NLANES];
      2'd2:    lane_nxt = cur_word[2*NLANES +: NLANES];
      default: lane_nxt = cur_word[3*NLANES +: NLANES];
    endcase

`ifdef RITC_TX_PRBS_TRAIN_EN
    if (sel ? train_i : train_q) lane_nxt = prbs_lanes;
`endif
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= WAIT_SYNC;
      phase_q     <= 2'd0;
      slot_q      <= '0;
      lane_o      <= '0;
      refclk_o    <= 1'b0;
      running_o   <= 1'b0;
      uflow_cnt_o <= '0;
    end else begin
      case (state_q)
        WAIT_SYNC: begin
          if (sync_i) begin
            state_q   <= RUN;
            running_o <= 1'b1;
          end
        end
        RUN: begin
          running_o <= 1'b1;
        end
        default: begin
          state_q   <= WAIT_SYNC;
          running_o <= 1'b0;
        end
      endcase

      // Outputs stay at their reset value until the first sync.
      if (adv) begin
        phase_q  <= phase_nxt;
        refclk_o <= ~phase_nxt[1];
        lane_o   <= lane_nxt;
        if (sel) slot_q <= slot_nxt;
      end

      if (uflow_clr_i)
        uflow_cnt_o <= '0;
      else if (uflow_hit && (uflow_cnt_o != '1))
        uflow_cnt_o <= uflow_cnt_o + UFLOW_ONE;
    end
  end

endmodule
